// File: rtl/uart_test_sequencer.sv
// Burst sequencer feeding a UART transmitter from an external counting data generator.
// Optional loopback checker enabled by defining UART_SEQ_CHECK_EN.
module uart_test_sequencer #(
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  burst_len,
    output logic        gen_start,
    input  logic [7:0]  gen_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] sent_cnt
`ifdef UART_SEQ_CHECK_EN
    ,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [7:0]  err_cnt
`endif
);

    typedef enum logic [2:0] {StIdle, StLoad, StSend, StGap, StDone} state_e;

    localparam logic [15:0] GapReload = 16'(GAP_CYCLES - 32'd1);

    state_e      state_q, state_d;
    logic [7:0]  remaining_q, remaining_d;
    logic        continuous_q, continuous_d;
    logic [15:0] gap_q, gap_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        gen_start_q, gen_start_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] sent_cnt_q, sent_cnt_d;
    logic        handshake;

    assign handshake = (state_q == StSend) && tx_valid_q && tx_ready;

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        continuous_d = continuous_q;
        gap_d        = gap_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        gen_start_d  = 1'b0;
        sent_cnt_d   = sent_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d      = StLoad;
                    remaining_d  = burst_len;
                    continuous_d = (burst_len == 8'd0);
                    sent_cnt_d   = 16'd0;
                end
            end
            StLoad: begin
                tx_data_d  = gen_data;
                tx_valid_d = 1'b1;
                state_d    = StSend;
            end
            StSend: begin
                // enable is ignored here: an offered byte is never withdrawn
                if (handshake) begin
                    tx_valid_d  = 1'b0;
                    gen_start_d = 1'b1;
                    sent_cnt_d  = sent_cnt_q + 16'd1;
                    if (!continuous_q) begin
                        remaining_d = remaining_q - 8'd1;
                    end
                    if (!continuous_q && remaining_q == 8'd1) begin
                        state_d = StDone;
                    end else if (!enable) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StGap;
                        gap_d   = GapReload;
                    end
                end
            end
            StGap: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (gap_q == 16'd0) begin
                    state_d = StLoad;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            StDone: begin
                if (!enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StLoad) || (state_d == StSend) || (state_d == StGap);
        done_d = (state_d == StDone) && (state_q != StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            remaining_q  <= 8'd0;
            continuous_q <= 1'b0;
            gap_q        <= 16'd0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'd0;
            gen_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sent_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            continuous_q <= continuous_d;
            gap_q        <= gap_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            gen_start_q  <= gen_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sent_cnt_q   <= sent_cnt_d;
        end
    end

    assign gen_start = gen_start_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sent_cnt  = sent_cnt_q;

`ifdef UART_SEQ_CHECK_EN
    logic       first_q, first_d;
    logic [7:0] expect_q, expect_d;
    logic [7:0] err_q, err_d;

    always_comb begin
        first_d  = first_q;
        expect_d = expect_q;
        err_d    = err_q;
        if (state_q == StIdle && enable) begin
            first_d = 1'b1;
            err_d   = 8'd0;
        end
        // Expected sequence is seeded from the generator on the first byte of a burst
        if (state_q == StLoad && first_q) begin
            first_d  = 1'b0;
            expect_d = gen_data;
        end else if (rx_valid) begin
            expect_d = expect_q + 8'd1;
            if (rx_data != expect_q && err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q  <= 1'b0;
            expect_q <= 8'd0;
            err_q    <= 8'd0;
        end else begin
            first_q  <= first_d;
            expect_q <= expect_d;
            err_q    <= err_d;
        end
    end

    assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_uart_test_sequencer.sv
// Scoreboard bench for uart_test_sequencer: stimulus pushes expected bytes, a monitor pops them.
module tb_uart_test_sequencer;

    localparam int unsigned GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        tx_ready;
    logic [7:0]  burst_len;
    logic        gen_start;
    logic [7:0]  gen_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;
    logic [15:0] sent_cnt;
`ifdef UART_SEQ_CHECK_EN
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  err_cnt;
`endif

    // Counting generator model: gen_data = base + number of gen_start pulses since clear
    logic [7:0] gen_base;
    logic [7:0] gen_cnt = 8'd0;
    logic       gen_clr;
    int         cyc = 0;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    int         rise_q[$];
    int         gs_cnt = 0;
    int         done_cnt = 0;
    logic       mon_pend = 1'b0;
    logic [7:0] mon_pend_data = 8'd0;
    logic       mon_prev_valid = 1'b0;

    always #5 clk = ~clk;

    assign gen_data = gen_base + gen_cnt;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (gen_clr) gen_cnt <= 8'd0;
        else if (gen_start) gen_cnt <= gen_cnt + 8'd1;
    end

    uart_test_sequencer #(
        .GAP_CYCLES(GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .burst_len(burst_len),
        .gen_start(gen_start),
        .gen_data (gen_data),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .sent_cnt (sent_cnt)
`ifdef UART_SEQ_CHECK_EN
        ,
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .err_cnt  (err_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gen_reset(input logic [7:0] base);
        gen_base = base;
        gen_clr  = 1'b1;
        tick(1);
        gen_clr  = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!tx_valid && n < 200) begin
            tick(1);
            n++;
        end
        if (!tx_valid) timeout(name);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 200) begin
            tick(1);
            n++;
        end
        if (!done) timeout(name);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks SEND holds steady
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && mon_pend) begin
                check("send_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, mon_pend_data});
            end
            if (tx_valid && !mon_prev_valid) rise_q.push_back(cyc);
            if (gen_start) gs_cnt++;
            if (done) done_cnt++;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_byte: got unexpected 0x%0h, want no byte", tx_data);
                end else begin
                    check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            mon_pend       = rst_n && tx_valid && !tx_ready;
            mon_pend_data  = tx_data;
            mon_prev_valid = tx_valid;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int r0;
        int g0;
        int d0;
        int n;
        logic [7:0] b;

        rst_n     = 1'b0;
        enable    = 1'b0;
        tx_ready  = 1'b0;
        burst_len = 8'd0;
        gen_base  = 8'd0;
        gen_clr   = 1'b1;
`ifdef UART_SEQ_CHECK_EN
        rx_valid  = 1'b0;
        rx_data   = 8'd0;
`endif
        tick(3);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_gen_start", {31'd0, gen_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sent_cnt", {16'd0, sent_cnt}, 32'd0);
        rst_n   = 1'b1;
        gen_clr = 1'b0;
        tick(2);

        // 3-byte burst, always-ready transmitter
        gen_reset(8'h00);
        r0 = rise_q.size(); g0 = gs_cnt; d0 = done_cnt;
        exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        burst_len = 8'd3;
        tx_ready  = 1'b1;
        enable    = 1'b1;
        wait_done("t1_done");
        tick(3);
        check("t1_rises", rise_q.size() - r0, 3);
        if (rise_q.size() - r0 == 3) begin
            check("t1_spacing0", rise_q[r0+1] - rise_q[r0], 6);
            check("t1_spacing1", rise_q[r0+2] - rise_q[r0+1], 6);
        end
        check("t1_gen_start", gs_cnt - g0, 3);
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_sent_cnt", {16'd0, sent_cnt}, 32'd3);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_sb_empty", exp_q.size(), 0);
        tick(10);
        check("t1_done_hold", done_cnt - d0, 1);
        check("t1_no_more", rise_q.size() - r0, 3);
        enable = 1'b0;
        tick(2);

        // Stalled transmitter with enable dropped while the byte is pending
        gen_reset(8'hA5);
        g0 = gs_cnt;
        tx_ready  = 1'b0;
        burst_len = 8'd0;
        exp_q.push_back(8'hA5);
        enable = 1'b1;
        wait_valid("t2_valid");
        enable = 1'b0;
        tick(10);
        check("t2_valid_held", {31'd0, tx_valid}, 32'd1);
        check("t2_data_held", {24'd0, tx_data}, 32'hA5);
        check("t2_busy", {31'd0, busy}, 32'd1);
        tx_ready = 1'b1;
        tick(1);
        check("t2_valid_drop", {31'd0, tx_valid}, 32'd0);
        check("t2_gen_start", {31'd0, gen_start}, 32'd1);
        check("t2_idle", {31'd0, busy}, 32'd0);
        check("t2_sent_cnt", {16'd0, sent_cnt}, 32'd1);
        r0 = rise_q.size();
        tick(12);
        check("t2_no_gap", rise_q.size() - r0, 0);
        check("t2_gs_once", gs_cnt - g0, 1);
        check("t2_sb_empty", exp_q.size(), 0);

        // Continuous mode, 300 bytes wrapping through 0xFF
        gen_reset(8'hFE);
        g0 = gs_cnt; d0 = done_cnt;
        for (int i = 0; i < 300; i++) begin
            b = 8'hFE + 8'(i);
            exp_q.push_back(b);
        end
        burst_len = 8'd0;
        tx_ready  = 1'b1;
        enable    = 1'b1;
        n = 0;
        while (sent_cnt != 16'd300 && n < 4000) begin
            tick(1);
            n++;
        end
        if (sent_cnt != 16'd300) timeout("t3_300");
        enable = 1'b0;
        tick(GAP + 4);
        check("t3_sent_cnt", {16'd0, sent_cnt}, 32'd300);
        check("t3_no_done", done_cnt - d0, 0);
        check("t3_gen_start", gs_cnt - g0, 300);
        check("t3_sb_empty", exp_q.size(), 0);
        check("t3_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of GAP
        gen_reset(8'h40);
        burst_len = 8'd0;
        tx_ready  = 1'b1;
        exp_q.push_back(8'h40);
        enable = 1'b1;
        n = 0;
        while (!gen_start && n < 200) begin
            tick(1);
            n++;
        end
        if (!gen_start) timeout("t4_gap");
        tick(2);
        rst_n = 1'b0;
        #1;
        check("t4g_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("t4g_busy", {31'd0, busy}, 32'd0);
        check("t4g_sent_cnt", {16'd0, sent_cnt}, 32'd0);
        check("t4g_tx_data", {24'd0, tx_data}, 32'd0);
        enable = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Reset in the middle of SEND: the pending byte is lost without gen_start
        gen_reset(8'h40);
        tx_ready = 1'b0;
        exp_q.push_back(8'h40);
        enable = 1'b1;
        wait_valid("t4_send");
        tick(2);
        g0 = gs_cnt;
        rst_n = 1'b0;
        #1;
        check("t4s_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("t4s_tx_data", {24'd0, tx_data}, 32'd0);
        check("t4s_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        enable = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("t4s_no_gen_start", gs_cnt - g0, 0);
        burst_len = 8'd1;
        tx_ready  = 1'b1;
        exp_q.push_back(8'h40);
        enable = 1'b1;
        wait_valid("t4_restart");
        check("t4r_sent_cnt0", {16'd0, sent_cnt}, 32'd0);
        wait_done("t4r_done");
        check("t4r_sent_cnt1", {16'd0, sent_cnt}, 32'd1);
        enable = 1'b0;
        tick(2);

        // burst_len changed mid-burst has no effect
        gen_reset(8'h20);
        r0 = rise_q.size(); d0 = done_cnt;
        exp_q.push_back(8'h20); exp_q.push_back(8'h21);
        burst_len = 8'd2;
        tx_ready  = 1'b1;
        enable    = 1'b1;
        wait_valid("t5_valid");
        burst_len = 8'd5;
        wait_done("t5_done");
        tick(30);
        check("t5_rises", rise_q.size() - r0, 2);
        check("t5_done_cnt", done_cnt - d0, 1);
        check("t5_sent_cnt", {16'd0, sent_cnt}, 32'd2);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_sb_empty", exp_q.size(), 0);
        enable = 1'b0;
        tick(2);
        burst_len = 8'd1;
        exp_q.push_back(8'h22);
        enable = 1'b1;
        wait_done("t5_restart");
        check("t5_restart_cnt", {16'd0, sent_cnt}, 32'd1);
        enable = 1'b0;
        tick(2);

`ifdef UART_SEQ_CHECK_EN
        // Loopback checker: one mismatch, then saturation
        gen_reset(8'h10);
        burst_len = 8'd1;
        tx_ready  = 1'b1;
        exp_q.push_back(8'h10);
        enable = 1'b1;
        wait_done("t6_done");
        enable = 1'b0;
        tick(1);
        check("t6_err_clear", {24'd0, err_cnt}, 32'd0);
        rx_data = 8'h10; rx_valid = 1'b1; tick(1);
        rx_data = 8'h11; tick(1);
        rx_data = 8'h13; tick(1);
        rx_valid = 1'b0;
        tick(1);
        check("t6_err_one", {24'd0, err_cnt}, 32'd1);
        for (int i = 0; i < 300; i++) begin
            rx_data  = 8'h93 + 8'(i);
            rx_valid = 1'b1;
            tick(1);
        end
        rx_valid = 1'b0;
        tick(1);
        check("t6_err_sat", {24'd0, err_cnt}, 32'd255);
        exp_q.push_back(8'h11);
        enable = 1'b1;
        wait_valid("t6_restart");
        check("t6_err_reload", {24'd0, err_cnt}, 32'd0);
        wait_done("t6_restart_done");
        enable = 1'b0;
        tick(2);
`endif

        tick(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_test_sequencer.md
UART_TEST_SEQUENCER -- requirements
Module: uart_test_sequencer

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16: idle cycles inserted between bytes; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable  input  1  level request to run bursts; deassertion aborts between bytes.
REQ-005 SHALL have port burst_len  input  8  bytes per burst, sampled on burst start; 0 means continuous.
REQ-006 SHALL have port gen_start  output  1  one-cycle pulse advancing the external 8-bit counting data generator.
REQ-007 SHALL have port gen_data  input  8  current generator value.
REQ-008 SHALL have port tx_valid  output  1  byte offered to UART transmitter.
REQ-009 SHALL have port tx_data  output  8  byte offered, stable while tx_valid=1.
REQ-010 SHALL have port tx_ready  input  1  transmitter accepts when tx_valid and tx_ready are both 1.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE and DONE.
REQ-012 SHALL have port done  output  1  one-cycle pulse on burst completion.
REQ-013 SHALL have port sent_cnt  output  16  bytes accepted in current burst.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, SEND, GAP, DONE, all outputs registered.
REQ-015 IDLE: enable=1 SHALL go to LOAD, latch burst_len into remaining counter and clear sent_cnt to 0.
REQ-016 LOAD: SHALL register tx_data <= gen_data, set tx_valid=1, go to SEND; lasts exactly one cycle.
REQ-017 SEND: SHALL hold tx_valid and tx_data until handshake; tx_valid never withdrawn before handshake, even if enable falls.
REQ-018 On handshake SHALL drop tx_valid next cycle, increment sent_cnt (wraps 0xFFFF->0), decrement remaining when burst_len!=0.
REQ-019 gen_start SHALL be high exactly the one cycle after each handshake, never otherwise.
REQ-020 After handshake: remaining reaching 0 (burst_len!=0) SHALL go DONE; else enable=0 SHALL go IDLE; else GAP.
REQ-021 GAP: SHALL stay exactly GAP_CYCLES cycles then go LOAD; enable=0 at any GAP cycle SHALL go IDLE next cycle.
REQ-022 DONE: done SHALL pulse on the entry cycle only; SHALL stay in DONE while enable=1 and go IDLE when enable=0.
REQ-023 burst_len changes after burst start SHALL have no effect until next IDLE->LOAD.
REQ-024 Handshake-to-tx_valid latency SHALL be GAP_CYCLES+2 cycles (1 SEND exit, GAP_CYCLES, 1 LOAD).

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, tx_valid=0, tx_data=0, gen_start=0, busy=0, done=0, sent_cnt=0, remaining=0, gap counter=0.
REQ-026 Reset mid-SEND SHALL drop tx_valid immediately without handshake; no gen_start issued for the lost byte.

Configuration
REQ-027 Macro UART_SEQ_CHECK_EN defined SHALL add ports rx_valid input 1, rx_data input 8, err_cnt output 8, and a loopback checker.
REQ-028 Checker SHALL load expected byte from gen_data at first LOAD of a burst; each rx_valid SHALL compare rx_data, increment expected (mod 256), and on mismatch increment err_cnt saturating at 255.
REQ-029 err_cnt SHALL reset to 0 on rst_n and on IDLE->LOAD; expected byte resets to 0.
REQ-030 Without UART_SEQ_CHECK_EN those ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 GAP_CYCLES=4, burst_len=3, tx_ready=1, gen_data starts 0x00 -> tx_data 0x00,0x01,0x02 with tx_valid rises 6 cycles apart, 3 gen_start pulses, done pulse once, sent_cnt=3.
REQ-032 tx_ready held 0 for 10 cycles in SEND, enable dropped meanwhile -> tx_valid and tx_data stable all 10 cycles; after handshake go IDLE, no GAP.
REQ-033 burst_len=0, enable=1 for 300 bytes, gen_data from 0xFE -> tx_data wraps 0xFF->0x00, no done pulse, sent_cnt=300.
REQ-034 rst_n asserted mid-GAP and mid-SEND -> all outputs 0 same cycle; re-enable restarts with sent_cnt=0.
REQ-035 UART_SEQ_CHECK_EN, loopback rx echoes 0x10,0x11,0x13 -> err_cnt=1; 300 forced mismatches -> err_cnt=255.
REQ-036 burst_len changed from 2 to 5 during burst, enable held 1 -> exactly 2 bytes, DONE held until enable=0.
